// File: rtl/mc_control_fsm.sv
// Multicycle main controller for the RV32I core: sequences fetch/decode/execute/
// memory/writeback and drives datapath selects, ALU operation and write strobes.
package mc_control_fsm_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;
endpackage

module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit TRAP_STICKY   = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       Zero_i,
  input  logic       AluLsb_i,
  input  logic       MemReady_i,
  output logic       PCWrite_o,
  output logic       AdrSrc_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic [1:0] ResultSrc_o,
  output logic [1:0] ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output alu_op_e    ALUControl_o,
  output logic [2:0] ImmSrc_o,
  output logic       RegWrite_o,
  output logic       IllegalInstr_o
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BRANCH, S_TRAP
  } state_e;

  state_e state, state_next;

  logic ready;
  logic pc_write, mem_write, ir_write, reg_write, illegal;
  logic branch_flag, branch_taken;

  assign ready = MEM_HANDSHAKE ? MemReady_i : 1'b1;

  // funct3[2] selects the SLT/SLTU flag over Zero; funct3[0] inverts the condition.
  assign branch_flag  = funct3_i[2] ? AluLsb_i : Zero_i;
  assign branch_taken = branch_flag ^ funct3_i[0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= S_FETCH;
    else         state <= state_next;
  end

  always_comb begin
    case (op_i)
      7'b0100011: ImmSrc_o = 3'b001;
      7'b1100011: ImmSrc_o = 3'b010;
      7'b1101111: ImmSrc_o = 3'b011;
      default:    ImmSrc_o = 3'b000;
    endcase
  end

  always_comb begin
    state_next   = state;
    pc_write     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    illegal      = 1'b0;
    AdrSrc_o     = 1'b0;
    ResultSrc_o  = 2'b00;
    ALUSrcA_o    = 2'b00;
    ALUSrcB_o    = 2'b00;
    ALUControl_o = ALU_ADD;

    case (state)
      S_FETCH: begin
        ALUSrcB_o   = 2'b10;
        ResultSrc_o = 2'b10;
        ir_write    = ready;
        pc_write    = ready;
        if (ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA_o = 2'b01;
        ALUSrcB_o = 2'b01;
        case (op_i)
          7'b0000011, 7'b0100011: state_next = S_MEMADR;
          7'b0110011:             state_next = S_EXECR;
          7'b0010011:             state_next = S_EXECI;
          7'b1101111:             state_next = S_JAL;
          7'b1100011:             state_next = (funct3_i[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
          default:                state_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA_o  = 2'b10;
        ALUSrcB_o  = 2'b01;
        state_next = op_i[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc_o = 1'b1;
        if (ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc_o = 2'b01;
        reg_write   = 1'b1;
        state_next  = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc_o  = 1'b1;
        mem_write = 1'b1;
        if (ready) state_next = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcA_o  = 2'b10;
        ALUSrcB_o  = (state == S_EXECI) ? 2'b01 : 2'b00;
        state_next = S_ALUWB;
        case (funct3_i)
          3'b000:  ALUControl_o = (state == S_EXECR && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  ALUControl_o = ALU_SLL;
          3'b010:  ALUControl_o = ALU_SLT;
          3'b011:  ALUControl_o = ALU_SLTU;
          3'b100:  ALUControl_o = ALU_XOR;
          3'b101:  ALUControl_o = funct7b5_i ? ALU_SRA : ALU_SRL;
          3'b110:  ALUControl_o = ALU_OR;
          default: ALUControl_o = ALU_AND;
        endcase
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA_o  = 2'b01;
        ALUSrcB_o  = 2'b10;
        pc_write   = 1'b1;
        state_next = S_ALUWB;
      end
      S_BRANCH: begin
        ALUSrcA_o  = 2'b10;
        pc_write   = branch_taken;
        state_next = S_FETCH;
        case (funct3_i[2:1])
          2'b00:   ALUControl_o = ALU_SUB;
          2'b10:   ALUControl_o = ALU_SLT;
          2'b11:   ALUControl_o = ALU_SLTU;
          default: ALUControl_o = ALU_ADD;
        endcase
      end
      S_TRAP: begin
        illegal = 1'b1;
        if (!TRAP_STICKY) state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Strobes are gated by rst_ni so nothing can fire while reset is held.
  assign PCWrite_o      = pc_write  & rst_ni;
  assign MemWrite_o     = mem_write & rst_ni;
  assign IRWrite_o      = ir_write  & rst_ni;
  assign RegWrite_o     = reg_write & rst_ni;
  assign IllegalInstr_o = illegal   & rst_ni;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: directed per-cycle vectors push expected
// control words; a monitor pops and compares one word per cycle.
module tb_mc_control_fsm;
  import mc_control_fsm_pkg::*;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    alu_op_e    alu;
    logic [2:0] imm;
    logic       rw;
    logic       ill;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'b0110011;
  logic [2:0] f3 = 3'b000;
  logic       f7 = 1'b0;
  logic       zero = 1'b0;
  logic       lsb = 1'b0;
  logic       mem_ready = 1'b1;

  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, src_a, src_b;
  logic [2:0] imm_src;
  alu_op_e    alu_ctl;

  logic [6:0] nxt_op = 7'b0110011;
  logic [2:0] nxt_f3 = 3'b000;
  logic       nxt_f7 = 1'b0;

  ctl_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    passes = 0;

  always #5 clk = ~clk;

  mc_control_fsm #(.MEM_HANDSHAKE(1'b1), .TRAP_STICKY(1'b1)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .op_i           (op),
    .funct3_i       (f3),
    .funct7b5_i     (f7),
    .Zero_i         (zero),
    .AluLsb_i       (lsb),
    .MemReady_i     (mem_ready),
    .PCWrite_o      (pc_write),
    .AdrSrc_o       (adr_src),
    .MemWrite_o     (mem_write),
    .IRWrite_o      (ir_write),
    .ResultSrc_o    (result_src),
    .ALUSrcA_o      (src_a),
    .ALUSrcB_o      (src_b),
    .ALUControl_o   (alu_ctl),
    .ImmSrc_o       (imm_src),
    .RegWrite_o     (reg_write),
    .IllegalInstr_o (illegal)
  );

  function automatic ctl_t mk(input logic pcw, input logic adr, input logic mw, input logic irw,
                              input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
                              input alu_op_e alu, input logic [2:0] imm, input logic rw,
                              input logic ill);
    ctl_t c;
    c.pcw = pcw; c.adr = adr; c.mw = mw; c.irw = irw; c.rs = rs; c.sa = sa; c.sb = sb;
    c.alu = alu; c.imm = imm; c.rw = rw; c.ill = ill;
    return c;
  endfunction

  function automatic ctl_t fetch_e(input logic [2:0] imm, input logic rdy);
    return mk(rdy, 1'b0, 1'b0, rdy, 2'b10, 2'b00, 2'b10, ALU_ADD, imm, 1'b0, 1'b0);
  endfunction

  function automatic ctl_t decode_e(input logic [2:0] imm);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, ALU_ADD, imm, 1'b0, 1'b0);
  endfunction

  function automatic ctl_t rst_e(input logic [2:0] imm);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, ALU_ADD, imm, 1'b0, 1'b0);
  endfunction

  function automatic ctl_t wb_e(input logic [2:0] imm);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, ALU_ADD, imm, 1'b1, 1'b0);
  endfunction

  function automatic ctl_t trap_e(input logic [2:0] imm);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, ALU_ADD, imm, 1'b0, 1'b1);
  endfunction

  task automatic instr(input logic [6:0] o, input logic [2:0] f, input logic b);
    nxt_op = o; nxt_f3 = f; nxt_f7 = b;
  endtask

  task automatic step(input logic rst, input logic z, input logic l, input logic rdy,
                      input ctl_t e, input string name);
    @(negedge clk);
    rst_n = rst; zero = z; lsb = l; mem_ready = rdy;
    op = nxt_op; f3 = nxt_f3; f7 = nxt_f7;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  initial begin : monitor
    ctl_t  act, e;
    string n;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        act = mk(pc_write, adr_src, mem_write, ir_write, result_src, src_a, src_b,
                 alu_ctl, imm_src, reg_write, illegal);
        checks++;
        if (act === e) passes++;
        else $display("FAIL %s: got pcw=%b adr=%b mw=%b irw=%b rs=%b sa=%b sb=%b alu=%0d imm=%b rw=%b ill=%b, want pcw=%b adr=%b mw=%b irw=%b rs=%b sa=%b sb=%b alu=%0d imm=%b rw=%b ill=%b",
                      n, act.pcw, act.adr, act.mw, act.irw, act.rs, act.sa, act.sb, act.alu,
                      act.imm, act.rw, act.ill, e.pcw, e.adr, e.mw, e.irw, e.rs, e.sa, e.sb,
                      e.alu, e.imm, e.rw, e.ill);
      end
    end
  end

  initial begin : stimulus
    instr(7'b0110011, 3'b000, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, rst_e(3'b000), "reset");

    // sub: R-type funct3 000 with funct7b5
    step(1'b1, 1'b0, 1'b0, 1'b1, fetch_e(3'b000, 1'b1), "sub_fetch");
    step(1'b1, 1'b0, 1'b0, 1'b1, decode_e(3'b000), "sub_decode");
    step(1'b1, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, ALU_SUB, 3'b000, 0, 0), "sub_exec");
    step(1'b1, 1'b0, 1'b0, 1'b1, wb_e(3'b000), "sub_wb");

    // addi with funct7b5 set must stay ADD
    instr(7'b0010011, 3'b000, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, fetch_e(3'b000, 1'b1), "addi_fetch");
    step(1'b1, 1'b0, 1'b0, 1'b1, decode_e(3'b000), "addi_decode");
    step(1'b1, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, ALU_ADD, 3'b000, 0, 0), "addi_exec");
    step(1'b1, 1'b0, 1'b0, 1'b1, wb_e(3'b000), "addi_wb");

    instr(7'b0010011, 3'b101, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, fetch_e(3'b000, 1'b1), "srai_fetch");
    step(1'b1, 1'b0, 1'b0, 1'b1, decode_e(3'b000), "srai_decode");
    step(1'b1, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, ALU_SRA, 3'b000, 0, 0), "srai_exec");
    step(1'b1, 1'b0, 1'b0, 1'b1, wb_e(3'b000), "srai_wb");

    // lw with a fetch stall and three wait cycles in MEMREAD
    instr(7'b0000011, 3'b010, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, fetch_e(3'b000, 1'b0), "lw_fetch_wait");
    step(1'b1, 1'b0, 1'b0, 1'b1, fetch_e(3'b000, 1'b1), "lw_fetch");
    step(1'b1, 1'b0, 1'b0, 1'b1, decode_e(3'b000), "lw_decode");
    step(1'b1, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, ALU_ADD, 3'b000, 0, 0), "lw_memadr");
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, ALU_ADD, 3'b000, 0, 0), "lw_memread_wait");
    step(1'b1, 1'b0, 1'b0, 1'b1, mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, ALU_ADD, 3'b000, 0, 0), "lw_memread");
    step(1'b1, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, ALU_ADD, 3'b000, 1, 0), "lw_memwb");

    // sw with two wait cycles: MemWrite held three cycles
    instr(7'b0100011, 3'b010, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, fetch_e(3'b001, 1'b1), "sw_fetch");
    step(1'b1, 1'b0, 1'b0, 1'b1, decode_e(3'b001), "sw_decode");
    step(1'b1, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, ALU_ADD, 3'b001, 0, 0), "sw_memadr");
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, ALU_ADD, 3'b001, 0, 0), "sw_memwrite_wait");
    step(1'b1, 1'b0, 1'b0, 1'b1, mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, ALU_ADD, 3'b001, 0, 0), "sw_memwrite");

    // branches
    instr(7'b1100011, 3'b101, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, fetch_e(3'b010, 1'b1), "bge_fetch");
    step(1'b1, 1'b0, 1'b0, 1'b1, decode_e(3'b010), "bge_decode");
    step(1'b1, 1'b0, 1'b0, 1'b1, mk(1, 0, 0, 0, 2'b00, 2'b10, 2'b00, ALU_SLT, 3'b010, 0, 0), "bge_taken");
    instr(7'b1100011, 3'b001, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, fetch_e(3'b010, 1'b1), "bne_fetch");
    step(1'b1, 1'b1, 1'b0, 1'b1, decode_e(3'b010), "bne_decode");
    step(1'b1, 1'b1, 1'b0, 1'b1, mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, ALU_SUB, 3'b010, 0, 0), "bne_not_taken");
    instr(7'b1100011, 3'b110, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, fetch_e(3'b010, 1'b1), "bltu_fetch");
    step(1'b1, 1'b0, 1'b1, 1'b1, decode_e(3'b010), "bltu_decode");
    step(1'b1, 1'b0, 1'b1, 1'b1, mk(1, 0, 0, 0, 2'b00, 2'b10, 2'b00, ALU_SLTU, 3'b010, 0, 0), "bltu_taken");

    // jal
    instr(7'b1101111, 3'b000, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, fetch_e(3'b011, 1'b1), "jal_fetch");
    step(1'b1, 1'b0, 1'b0, 1'b1, decode_e(3'b011), "jal_decode");
    step(1'b1, 1'b0, 1'b0, 1'b1, mk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, ALU_ADD, 3'b011, 0, 0), "jal_jump");
    step(1'b1, 1'b0, 1'b0, 1'b1, wb_e(3'b011), "jal_wb");

    // reset asserted mid-store aborts MemWrite immediately
    instr(7'b0100011, 3'b010, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, fetch_e(3'b001, 1'b1), "sw2_fetch");
    step(1'b1, 1'b0, 1'b0, 1'b1, decode_e(3'b001), "sw2_decode");
    step(1'b1, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, ALU_ADD, 3'b001, 0, 0), "sw2_memadr");
    step(1'b1, 1'b0, 1'b0, 1'b0, mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, ALU_ADD, 3'b001, 0, 0), "sw2_memwrite");
    step(1'b0, 1'b0, 1'b0, 1'b0, rst_e(3'b001), "sw2_abort");

    // branch funct3 010 is illegal; trap is sticky until reset
    instr(7'b1100011, 3'b010, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, fetch_e(3'b010, 1'b1), "bad_br_fetch");
    step(1'b1, 1'b0, 1'b0, 1'b1, decode_e(3'b010), "bad_br_decode");
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1, trap_e(3'b010), "bad_br_trap");
    step(1'b0, 1'b0, 1'b0, 1'b1, rst_e(3'b010), "bad_br_reset");

    // lui is unsupported
    instr(7'b0110111, 3'b000, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, fetch_e(3'b000, 1'b1), "lui_fetch");
    step(1'b1, 1'b0, 1'b0, 1'b1, decode_e(3'b000), "lui_decode");
    repeat (10) step(1'b1, 1'b0, 1'b0, 1'b1, trap_e(3'b000), "lui_trap");
    step(1'b0, 1'b0, 1'b0, 1'b1, rst_e(3'b000), "lui_reset");
    step(1'b1, 1'b0, 1'b0, 1'b1, fetch_e(3'b000, 1'b1), "post_reset_fetch");

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expected words unchecked, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
